// File: rtl/regfile_wport_arbiter.sv
// Round-robin arbiter that shares the register-file write port between the ALU path (req0)
// and the multicycle path (req1), with a per-register pending-write scoreboard for RAW stalls.
module regfile_wport_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [ADDR_W-1:0]     req0_reg,
    input  logic [DATA_W-1:0]     req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_W-1:0]     req1_reg,
    input  logic [DATA_W-1:0]     req1_data,
    output logic                  req1_ready,
    input  logic                  rsv_valid,
    input  logic [ADDR_W-1:0]     rsv_reg,
    output logic                  rf_write,
    output logic [ADDR_W-1:0]     rf_wreg,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [2**ADDR_W-1:0]  busy,
    output logic                  rsv_conflict
);

    localparam int NREG = 2**ADDR_W;

    logic                last_grant;
    logic                grant0;
    logic                grant1;
    logic                xfer;
    logic                issue;
    logic [ADDR_W-1:0]   sel_reg;
    logic [DATA_W-1:0]   sel_data;
    logic                rsv_set;
    logic                rsv_hit;
    logic [NREG-1:0]     busy_next;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        // Under contention the requester that did not win last time goes first.
        if (!rst) begin
            if (req0_valid && (!req1_valid || last_grant)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
        xfer     = grant0 | grant1;
        sel_reg  = grant1 ? req1_reg  : req0_reg;
        sel_data = grant1 ? req1_data : req0_data;
        issue    = xfer && (sel_reg != '0);
    end

    always_comb begin
        rsv_set = rsv_valid && (rsv_reg != '0);
        // A reservation landing on the register being written this cycle is a fresh one, not a conflict.
        rsv_hit = rsv_set && busy[rsv_reg] && !(rf_write && (rf_wreg == rsv_reg));
        busy_next = busy;
        if (rf_write) begin
            busy_next[rf_wreg] = 1'b0;
        end
        if (rsv_set) begin
            busy_next[rsv_reg] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write     <= 1'b0;
            rf_wreg      <= '0;
            rf_wdata     <= '0;
            busy         <= '0;
            rsv_conflict <= 1'b0;
            last_grant   <= 1'b1;
        end else begin
            rf_write <= issue;
            if (issue) begin
                rf_wreg  <= sel_reg;
                rf_wdata <= sel_data;
            end
            if (xfer) begin
                last_grant <= grant1;
            end
            busy         <= busy_next;
            rsv_conflict <= rsv_hit;
        end
    end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Cycle-by-cycle vector bench for regfile_wport_arbiter: each row gives that cycle's inputs
// and the outputs expected to be visible during the same cycle.
module tb_regfile_wport_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req1_valid, rsv_valid;
    logic [ADDR_W-1:0] req0_reg, req1_reg, rsv_reg;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              req0_ready, req1_ready;
    logic              rf_write;
    logic [ADDR_W-1:0] rf_wreg;
    logic [DATA_W-1:0] rf_wdata;
    logic [31:0]       busy;
    logic              rsv_conflict;

    int checks = 0;
    int errors = 0;

    regfile_wport_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
        .rf_write(rf_write), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
        .busy(busy), .rsv_conflict(rsv_conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v0;
        logic [4:0]  r0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  r1;
        logic [31:0] d1;
        logic        rv;
        logic [4:0]  rr;
        logic        chk;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        e_wr;
        logic        chkw;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata;
        logic [31:0] e_busy;
        logic        e_conf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                                input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                                input logic rv, input logic [4:0] rr, input logic chk,
                                input logic e0, input logic e1, input logic ew, input logic chkw,
                                input logic [4:0] ewr, input logic [31:0] ewd,
                                input logic [31:0] eb, input logic ec);
        vec_t v;
        v.rst = r; v.v0 = v0; v.r0 = r0; v.d0 = d0; v.v1 = v1; v.r1 = r1; v.d1 = d1;
        v.rv = rv; v.rr = rr; v.chk = chk; v.e_rdy0 = e0; v.e_rdy1 = e1; v.e_wr = ew;
        v.chkw = chkw; v.e_wreg = ewr; v.e_wdata = ewd; v.e_busy = eb; v.e_conf = ec;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst;
        req0_valid = v.v0; req0_reg = v.r0; req0_data = v.d0;
        req1_valid = v.v1; req1_reg = v.r1; req1_data = v.d1;
        rsv_valid = v.rv; rsv_reg = v.rr;
    endtask

    localparam logic [31:0] B7  = 32'h1 << 7;
    localparam logic [31:0] B9  = 32'h1 << 9;
    localparam logic [31:0] B2  = 32'h1 << 2;
    localparam logic [31:0] B12 = 32'h1 << 12;

    initial begin
        //                 rst v0 r0  d0            v1 r1  d1     rv rr chk rdy0 rdy1 wr chkw wreg wdata        busy     conf
        tbl.push_back(mk(1, 0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0,            0,       0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 1, 0, 0, 0, 1, 0, 0,            0,       0));
        // single req0 write, one-cycle issue latency
        tbl.push_back(mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,     0, 0, 1, 1, 0, 0, 0, 0, 0,            0,       0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 1, 0, 0, 1, 1, 5, 32'hDEADBEEF, 0,       0));
        tbl.push_back(mk(1, 0, 0, 0,            0, 0, 0,     0, 0, 1, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0,       0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 1, 0, 0, 0, 1, 0, 0,            0,       0));
        // sustained contention alternates 0,1,0,1
        tbl.push_back(mk(0, 1, 3, 32'h11,       1, 4, 32'h22, 0, 0, 1, 1, 0, 0, 0, 0, 0,            0,       0));
        tbl.push_back(mk(0, 1, 3, 32'h11,       1, 4, 32'h22, 0, 0, 1, 0, 1, 1, 1, 3, 32'h11,       0,       0));
        tbl.push_back(mk(0, 1, 3, 32'h11,       1, 4, 32'h22, 0, 0, 1, 1, 0, 1, 1, 4, 32'h22,       0,       0));
        tbl.push_back(mk(0, 1, 3, 32'h11,       1, 4, 32'h22, 0, 0, 1, 0, 1, 1, 1, 3, 32'h11,       0,       0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 1, 0, 0, 1, 1, 4, 32'h22,       0,       0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 1, 0, 0, 0, 1, 4, 32'h22,       0,       0));
        // reserve 7, write it from req1, busy drops after the rf write cycle
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,     1, 7, 1, 0, 0, 0, 0, 0, 0,            0,       0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 1, 0, 0, 0, 0, 0, 0,            B7,      0));
        tbl.push_back(mk(0, 0, 0, 0,            1, 7, 32'h77, 0, 0, 1, 0, 1, 0, 0, 0, 0,            B7,      0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 1, 0, 0, 1, 1, 7, 32'h77,       B7,      0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 1, 0, 0, 0, 0, 0, 0,            0,       0));
        // re-reserve 9 in its clear cycle (no conflict), then again (conflict)
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,     1, 9, 1, 0, 0, 0, 0, 0, 0,            0,       0));
        tbl.push_back(mk(0, 1, 9, 32'h99,       0, 0, 0,     0, 0, 1, 1, 0, 0, 0, 0, 0,            B9,      0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,     1, 9, 1, 0, 0, 1, 1, 9, 32'h99,       B9,      0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,     1, 9, 1, 0, 0, 0, 0, 0, 0,            B9,      0));
        tbl.push_back(mk(0, 0, 0, 0,            1, 10, 32'hA0, 0, 0, 1, 0, 1, 0, 0, 0, 0,           B9,      1));
        // reg 0 write and reserve: accepted, no write, counts for round robin
        tbl.push_back(mk(0, 1, 0, 32'h55,       0, 0, 0,     1, 0, 1, 1, 0, 1, 1, 10, 32'hA0,      B9,      0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 1, 0, 0, 0, 0, 0, 0,            B9,      0));
        tbl.push_back(mk(0, 1, 3, 32'h11,       1, 4, 32'h22, 0, 0, 1, 0, 1, 0, 0, 0, 0,            B9,      0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 1, 0, 0, 1, 1, 4, 32'h22,       B9,      0));
        // reset while a write issues and both requesters wait
        tbl.push_back(mk(0, 1, 3, 32'h33,       0, 0, 0,     1, 2, 1, 1, 0, 0, 0, 0, 0,            B9,      0));
        tbl.push_back(mk(1, 1, 5, 32'h55,       1, 6, 32'h66, 0, 0, 1, 0, 0, 1, 1, 3, 32'h33,       B9 | B2, 0));
        tbl.push_back(mk(0, 1, 5, 32'h55,       1, 6, 32'h66, 0, 0, 1, 1, 0, 0, 1, 0, 0,            0,       0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 1, 0, 0, 1, 1, 5, 32'h55,       0,       0));
        tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 1, 0, 0, 0, 1, 5, 32'h55,       0,       0));

        drive(tbl[0]);
        @(posedge clk); #1;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge clk);
            if (tbl[i].chk) begin
                check("req0_ready", i, {31'b0, req0_ready}, {31'b0, tbl[i].e_rdy0});
                check("req1_ready", i, {31'b0, req1_ready}, {31'b0, tbl[i].e_rdy1});
                check("rf_write", i, {31'b0, rf_write}, {31'b0, tbl[i].e_wr});
                check("busy", i, busy, tbl[i].e_busy);
                check("rsv_conflict", i, {31'b0, rsv_conflict}, {31'b0, tbl[i].e_conf});
                if (tbl[i].chkw) begin
                    check("rf_wreg", i, {27'b0, rf_wreg}, {27'b0, tbl[i].e_wreg});
                    check("rf_wdata", i, rf_wdata, tbl[i].e_wdata);
                end
            end
            @(posedge clk); #1;
        end

        // back-to-back reservations of 12: second one conflicts for exactly one cycle
        rst = 0; req0_valid = 0; req1_valid = 0; rsv_valid = 1; rsv_reg = 5'd12;
        @(posedge clk); #1;
        @(negedge clk);
        check("seq busy12 set", 100, busy, B12);
        check("seq conflict pre", 100, {31'b0, rsv_conflict}, 32'd0);
        @(posedge clk); #1;
        rsv_valid = 0;
        @(negedge clk);
        check("seq conflict pulse", 101, {31'b0, rsv_conflict}, 32'd1);
        check("seq busy12 held", 101, busy, B12);
        @(posedge clk); #1;
        @(negedge clk);
        check("seq conflict drop", 102, {31'b0, rsv_conflict}, 32'd0);
        check("seq no write", 102, {31'b0, rf_write}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
